// File: rtl/weight_bank_loader.sv
// -----------------------------------------------------------------------------
// weight_bank_loader
//
// Loads one layer's 3x3 kernels from a synchronous weight ROM into a shadow
// register bank. The shadow bank is later copied into the active bank that
// drives the PE array. Because of this double buffering, the next layer's
// weights can load while the current layer computes.
//
// Ports
//   clk          single clock
//   rstn         asynchronous reset, active HIGH (asserted = 1)
//   i_load_en    one-cycle load request (see handshake note below)
//   i_base_addr  ROM address of kernel 0, sampled when the request is accepted
//   i_swap       consumer is finished with the active bank; permits a swap
//   o_rom_en     ROM read enable
//   o_rom_addr   ROM read address
//   i_rom_data   ROM read data, valid exactly one clock after o_rom_en
//   o_busy       load in progress, or shadow bank full and awaiting swap
//   o_ready      active bank holds valid weights (falls only on reset)
//   o_kernels    active bank; kernel k at [k*KERNEL_WIDTH +: KERNEL_WIDTH]
//   dbg_state    current FSM state (IDLE=0, READ=1, DRAIN=2)
//
// Handshake: a load request is accepted on a rising edge only when
// i_load_en=1 and o_busy=0 on that edge. A request seen while o_busy=1 is
// dropped; it is neither queued nor flagged. o_busy acts as the inverse of
// "ready" for the request channel. The ROM side has no back-pressure: every
// cycle with o_rom_en=1 returns exactly one word on the following cycle.
// -----------------------------------------------------------------------------
module weight_bank_loader #(
  parameter int WEIGHT_W     = 8,
  parameter int KERNEL_WIDTH = 9 * WEIGHT_W,
  parameter int NUM_KERNELS  = 12,
  parameter int ROM_AW       = 10
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                i_load_en,
  input  logic [ROM_AW-1:0]                   i_base_addr,
  input  logic                                i_swap,
  output logic                                o_rom_en,
  output logic [ROM_AW-1:0]                   o_rom_addr,
  input  logic [KERNEL_WIDTH-1:0]             i_rom_data,
  output logic                                o_busy,
  output logic                                o_ready,
  output logic [NUM_KERNELS*KERNEL_WIDTH-1:0] o_kernels,
  output logic [1:0]                          dbg_state
);

  // A counter must hold 0..NUM_KERNELS-1. It is kept at least 1 bit wide so
  // that the NUM_KERNELS=1 build still has a legal vector.
  localparam int CNT_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_KERNELS - 1);
  localparam int BANK_W = NUM_KERNELS * KERNEL_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ROM_AW-1:0]   base_q;
  logic [CNT_W-1:0]    rd_cnt;
  logic [CNT_W-1:0]    wr_cnt;
  logic                rd_vld;       // a read was issued last cycle; data is on i_rom_data now
  logic                shadow_full;
  logic                ready_q;
  logic [BANK_W-1:0]   shadow_q;
  logic [BANK_W-1:0]   active_q;

  logic                load_accept;
  logic                rom_en;
  logic [ROM_AW-1:0]   rom_addr;
  logic                busy;
  logic                swap_now;

  assign busy = (state_q != IDLE) || shadow_full;

  // The swap uses the registered shadow_full. An i_swap that arrives on the
  // same edge where the final word lands therefore waits until the next edge.
  // When no valid active bank exists yet, the swap happens without i_swap.
  assign swap_now = shadow_full && (i_swap || !ready_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and ROM-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    load_accept = 1'b0;
    rom_en      = 1'b0;
    rom_addr    = '0;
    case (state_q)
      IDLE: begin
        if (i_load_en && !busy) begin
          load_accept = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        rom_en   = 1'b1;
        // The address wraps silently at the top of the ROM.
        rom_addr = base_q + ROM_AW'(rd_cnt);
        if (rd_cnt == LAST_IDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once the final word has been captured into the shadow bank.
        if (rd_vld && (wr_cnt == LAST_IDX)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address/counter bookkeeping and read-valid pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      base_q <= '0;
      rd_cnt <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rom_en;
      if (load_accept) begin
        base_q <= i_base_addr;
        rd_cnt <= '0;
      end else if (rom_en) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow bank capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_cnt      <= '0;
      shadow_q    <= '0;
      shadow_full <= 1'b0;
    end else begin
      if (load_accept) begin
        wr_cnt <= '0;
      end else if (rd_vld) begin
        for (int k = 0; k < NUM_KERNELS; k++) begin
          if (wr_cnt == CNT_W'(k)) begin
            shadow_q[k*KERNEL_WIDTH +: KERNEL_WIDTH] <= i_rom_data;
          end
        end
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
      // Capture and swap never coincide. Capture happens only while a load is
      // running, and a load can start only when shadow_full is clear.
      if (rd_vld && (wr_cnt == LAST_IDX)) begin
        shadow_full <= 1'b1;
      end else if (swap_now) begin
        shadow_full <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Active bank: it changes only on a swap edge, and ready is sticky.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      active_q <= '0;
      ready_q  <= 1'b0;
    end else if (swap_now) begin
      active_q <= shadow_q;
      ready_q  <= 1'b1;
    end
  end

  assign o_rom_en   = rom_en;
  assign o_rom_addr = rom_addr;
  assign o_busy     = busy;
  assign o_ready    = ready_q;
  assign o_kernels  = active_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/weight_bank_loader.md
Name: weight_bank_loader

Overview:
- Parametrised successor to the fixed 12-kernel weight controller.
- Fetches a layer's 3x3 kernels from a synchronous weight ROM into a shadow register bank, then swaps them into an active bank that drives the conv array.
- Double buffering lets the next layer's weights load while the current layer computes.
- Sits between the weight ROM (layers 0/2/4) and the PE array kernel inputs.

Parameters:
- WEIGHT_W, 8, bits per weight.
- KERNEL_WIDTH, 9*WEIGHT_W, bits per kernel (one ROM word = one kernel).
- NUM_KERNELS, 12, kernels per bank; range 1..64.
- ROM_AW, 10, ROM address width.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous, active-high reset (asserted = 1).
- i_load_en  in  1  one-cycle load request; accepted only when o_busy=0.
- i_base_addr  in  ROM_AW  ROM address of kernel 0 for the layer; sampled on acceptance.
- i_swap  in  1  consumer finished with active bank; permits swap.
- o_rom_en  out  1  ROM read enable.
- o_rom_addr  out  ROM_AW  ROM read address.
- i_rom_data  in  KERNEL_WIDTH  ROM read data, valid exactly 1 clk after o_rom_en.
- o_busy  out  1  load in progress or shadow bank full awaiting swap.
- o_ready  out  1  active bank holds valid weights.
- o_kernels  out  NUM_KERNELS*KERNEL_WIDTH  active bank; kernel k at bits [k*KERNEL_WIDTH +: KERNEL_WIDTH].

Behaviour:
- Reset (async, rstn=1):
  - State IDLE; both banks zeroed.
  - o_ready=0, o_busy=0, o_rom_en=0, o_rom_addr=0, o_kernels=0.
  - Shadow-full flag and counters cleared.
- Reset mid-load: load is abandoned completely; after release the block behaves as freshly reset.
- FSM states:
  - IDLE: on i_load_en && !o_busy, latch i_base_addr, clear counters -> READ.
  - READ: each cycle o_rom_en=1, o_rom_addr=base+rd_cnt (mod 2^ROM_AW, wraps silently), rd_cnt++. When rd_cnt reaches NUM_KERNELS-1 on issue -> DRAIN.
  - DRAIN: o_rom_en=0; wait for the final data word -> IDLE.
- Capture:
  - A valid-delay register (1 stage) tracks issued reads.
  - On each returning word: shadow[wr_cnt] <= i_rom_data, wr_cnt++.
  - On the last word, set shadow_full.
- Swap: when shadow_full && (i_swap || !o_ready), copy shadow to active, set o_ready=1, clear shadow_full. i_swap with no shadow_full is ignored.
- o_busy = (state != IDLE) || shadow_full.
- Request rules: i_load_en while o_busy is dropped; no queueing and no error flag.
- Timing from accepting edge E0 (no prior active bank): ROM reads issued at edges E0..E(N-1)+1; shadow_full set at edge E(N+1); o_ready=1 and o_kernels updated at edge E(N+2), where N = NUM_KERNELS.
- Double buffering:
  - Active bank and o_ready are unchanged during a load.
  - o_kernels changes only on a swap edge.
  - o_ready never falls except on reset.
- Simultaneous events:
  - i_swap arriving on the same edge shadow_full sets does not swap. The swap occurs on the next edge where i_swap=1 or active is invalid.
  - A swap and a new i_load_en on the same edge: load is rejected, because o_busy is still 1 that cycle.
- NUM_KERNELS=1: READ lasts one cycle, then DRAIN.

Test Plan:
- Reset then load: N=12, base=0x010, ROM word[a]={9{a[7:0]}}. Expect o_rom_addr 0x010..0x01B on consecutive cycles, o_ready=1 at E14, kernel k = {9{8'h10+k}}, o_busy=0 after.
- Double buffer: with bank A active, load base=0x100. Expect o_kernels unchanged and o_busy=1 until i_swap=1. After i_swap, kernel0={9{8'h00}} (addr 0x100 low byte), o_busy=0 next cycle.
- Rejected request: pulse i_load_en during READ and while shadow_full=1. Expect no extra ROM reads and base address unchanged.
- Wrap-around: base=0x3FA, N=12. Expect addresses 0x3FA..0x3FF then 0x000..0x005; kernel6 comes from addr 0x000.
- Reset mid-load: assert rstn at rd_cnt=5. Expect all outputs 0 immediately (async). A subsequent load of base=0x020 completes normally with o_ready at E14.
- NUM_KERNELS=1 build: base=0x007. Expect a single o_rom_en pulse, o_ready at E3, o_kernels={9{8'h07}}.
